// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard unit for the pipelined MIPS core. It sits beside the ID/EX register
// and does two jobs:
//   - Picks the forwarding source for each EX-stage operand: EX/MEM, MEM/WB,
//     or a short history of retired write-backs.
//   - Runs the load-use stall machine. The stall freezes PC and IF/ID and
//     bubbles ID/EX for LOAD_LAT cycles.
// Register 0 is never forwarded and never recorded in the history.
module hazard_forward_unit #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int NSRC     = 2,
    parameter int HIST     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   ifid_src_addr,
    input  logic [NSRC-1:0]      ifid_src_used,
    input  logic [NSRC*AW-1:0]   idex_src_addr,
    input  logic                 idex_is_load,
    input  logic                 idex_wb,
    input  logic [AW-1:0]        idex_waddr,
    input  logic                 exmem_wb,
    input  logic [AW-1:0]        exmem_waddr,
    input  logic                 memwb_wb,
    input  logic [AW-1:0]        memwb_waddr,
    input  logic [DW-1:0]        memwb_wdata,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic [NSRC*DW-1:0]   hist_data,
    output logic                 stall,
    output logic                 flush_idex
);

    localparam int CW = $clog2(LOAD_LAT) + 1;

    typedef enum logic {
        S_IDLE,
        S_STALL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            lu;
    logic            stall_raw;

    logic            hist_v [HIST];
    logic [AW-1:0]   hist_a [HIST];
    logic [DW-1:0]   hist_d [HIST];

    // History valid bits: shift every cycle (MEM/WB keeps draining during stalls); writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HIST; k++) begin
                hist_v[k] <= 1'b0;
            end
        end else begin
            hist_v[0] <= memwb_wb && (memwb_waddr != '0);
            for (int k = 1; k < HIST; k++) begin
                hist_v[k] <= hist_v[k-1];
            end
        end
    end

    // History address/data: payload only matters where the valid bit is set, so no reset needed
    always_ff @(posedge clk) begin
        hist_a[0] <= memwb_waddr;
        hist_d[0] <= memwb_wdata;
        for (int k = 1; k < HIST; k++) begin
            hist_a[k] <= hist_a[k-1];
            hist_d[k] <= hist_d[k-1];
        end
    end

    // Per-operand forwarding select: EX/MEM, then MEM/WB, then youngest history hit
    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        logic [DW-1:0] hd;
        logic [1:0]    sel;
        fwd_sel   = '0;
        hist_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            a   = idex_src_addr[i*AW +: AW];
            hit = 1'b0;
            hd  = '0;
            sel = 2'd0;
            for (int k = HIST - 1; k >= 0; k--) begin
                if (hist_v[k] && (hist_a[k] == a)) begin
                    hit = 1'b1;
                    hd  = hist_d[k];
                end
            end
            if (a != '0) begin
                if (exmem_wb && (exmem_waddr == a)) begin
                    sel = 2'd1;
                end else if (memwb_wb && (memwb_waddr == a)) begin
                    sel = 2'd2;
                end else if (hit) begin
                    sel = 2'd3;
                    hist_data[i*DW +: DW] = hd;
                end
            end
            fwd_sel[i*2 +: 2] = sel;
        end
    end

    // Load-use detect: a load in EX targets a register the ID instruction really reads
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            lu = lu | (ifid_src_used[i] && (ifid_src_addr[i*AW +: AW] == idex_waddr));
        end
        lu = lu & idex_is_load & idex_wb & (idex_waddr != '0);
    end

    // Stall state register and remaining-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Stall sequencing: the detect cycle stalls by itself; STALL covers the remaining LOAD_LAT-1 cycles
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_raw  = 1'b0;
        case (state)
            S_IDLE: begin
                stall_raw = lu;
                if (lu && (LOAD_LAT > 1)) begin
                    state_next = S_STALL;
                    cnt_next   = CW'(LOAD_LAT - 1);
                end
            end
            S_STALL: begin
                stall_raw = 1'b1;
                cnt_next  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pipeline control outputs are held low while reset is asserted
    always_comb begin
        stall      = stall_raw & ~reset;
        flush_idex = stall_raw & ~reset;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Directed bench. Two units share one set of inputs:
//   - u_dut3: LOAD_LAT=3, HIST=2.
//   - u_dut1: LOAD_LAT=1, HIST=1.
// Each cycle's expected response is queued by the driver. A negedge monitor
// pops each entry and compares it against the outputs.
module tb_hazard_forward_unit;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NSRC = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC*AW-1:0]   ifid_src_addr;
    logic [NSRC-1:0]      ifid_src_used;
    logic [NSRC*AW-1:0]   idex_src_addr;
    logic                 idex_is_load;
    logic                 idex_wb;
    logic [AW-1:0]        idex_waddr;
    logic                 exmem_wb;
    logic [AW-1:0]        exmem_waddr;
    logic                 memwb_wb;
    logic [AW-1:0]        memwb_waddr;
    logic [DW-1:0]        memwb_wdata;

    logic [NSRC*2-1:0]    fwd_sel3;
    logic [NSRC*DW-1:0]   hist_data3;
    logic                 stall3;
    logic                 flush3;
    logic [NSRC*2-1:0]    fwd_sel1;
    logic [NSRC*DW-1:0]   hist_data1;
    logic                 stall1;
    logic                 flush1;

    typedef struct packed {
        logic [3:0]  sel;
        logic [63:0] hd;
        logic        st3;
        logic        st1;
    } exp_t;

    exp_t   exp_q[$];
    string  name_q[$];
    exp_t   mon_e;
    string  mon_n;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.AW(AW), .DW(DW), .NSRC(NSRC), .HIST(2), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .ifid_src_addr(ifid_src_addr), .ifid_src_used(ifid_src_used),
        .idex_src_addr(idex_src_addr), .idex_is_load(idex_is_load),
        .idex_wb(idex_wb), .idex_waddr(idex_waddr),
        .exmem_wb(exmem_wb), .exmem_waddr(exmem_waddr),
        .memwb_wb(memwb_wb), .memwb_waddr(memwb_waddr), .memwb_wdata(memwb_wdata),
        .fwd_sel(fwd_sel3), .hist_data(hist_data3), .stall(stall3), .flush_idex(flush3)
    );

    hazard_forward_unit #(.AW(AW), .DW(DW), .NSRC(NSRC), .HIST(1), .LOAD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ifid_src_addr(ifid_src_addr), .ifid_src_used(ifid_src_used),
        .idex_src_addr(idex_src_addr), .idex_is_load(idex_is_load),
        .idex_wb(idex_wb), .idex_waddr(idex_waddr),
        .exmem_wb(exmem_wb), .exmem_waddr(exmem_waddr),
        .memwb_wb(memwb_wb), .memwb_waddr(memwb_waddr), .memwb_wdata(memwb_wdata),
        .fwd_sel(fwd_sel1), .hist_data(hist_data1), .stall(stall1), .flush_idex(flush1)
    );

    // Compare one field and account for it in the totals
    task automatic checkOutput(input string name, input string field,
                               input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
        end
    endtask

    // Queue the expected response for the vector just driven
    task automatic applyStimulus(input string name, input logic [3:0] sel,
                                 input logic [63:0] hd, input logic st3, input logic st1);
        exp_t e;
        e.sel = sel;
        e.hd  = hd;
        e.st3 = st3;
        e.st1 = st1;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Advance to just after the next rising edge and return all inputs to idle
    task automatic nextCycle();
        @(posedge clk);
        #1;
        reset         = 1'b0;
        ifid_src_addr = '0;
        ifid_src_used = '0;
        idex_src_addr = '0;
        idex_is_load  = 1'b0;
        idex_wb       = 1'b0;
        idex_waddr    = '0;
        exmem_wb      = 1'b0;
        exmem_waddr   = '0;
        memwb_wb      = 1'b0;
        memwb_waddr   = '0;
        memwb_wdata   = '0;
    endtask

    task automatic setSrc(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
        idex_src_addr = {s1, s0};
    endtask

    task automatic setMemwb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwb_wb    = 1'b1;
        memwb_waddr = a;
        memwb_wdata = d;
    endtask

    task automatic setLoad(input logic [AW-1:0] w, input logic [AW-1:0] i0,
                           input logic [AW-1:0] i1, input logic [1:0] used);
        idex_is_load  = 1'b1;
        idex_wb       = 1'b1;
        idex_waddr    = w;
        ifid_src_addr = {i1, i0};
        ifid_src_used = used;
    endtask

    // Monitor: every cycle with a queued expectation is checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checkOutput(mon_n, "fwd_sel",   64'(fwd_sel3),   64'(mon_e.sel));
            checkOutput(mon_n, "hist_data", 64'(hist_data3), mon_e.hd);
            checkOutput(mon_n, "stall_ll3", 64'(stall3),     64'(mon_e.st3));
            checkOutput(mon_n, "flush_ll3", 64'(flush3),     64'(mon_e.st3));
            checkOutput(mon_n, "stall_ll1", 64'(stall1),     64'(mon_e.st1));
            checkOutput(mon_n, "flush_ll1", 64'(flush1),     64'(mon_e.st1));
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        int guard;
        reset         = 1'b1;
        ifid_src_addr = '0;
        ifid_src_used = '0;
        idex_src_addr = '0;
        idex_is_load  = 1'b0;
        idex_wb       = 1'b0;
        idex_waddr    = '0;
        exmem_wb      = 1'b0;
        exmem_waddr   = '0;
        memwb_wb      = 1'b0;
        memwb_waddr   = '0;
        memwb_wdata   = '0;

        repeat (2) begin
            nextCycle();
            reset = 1'b1;
            setMemwb(5'd7, 32'h77);
            setSrc(5'd7, 5'd0);
            setLoad(5'd3, 5'd3, 5'd0, 2'b01);
            applyStimulus("reset_hold", 4'b0010, 64'd0, 1'b0, 1'b0);
        end

        nextCycle(); setSrc(5'd7, 5'd0);
        applyStimulus("hist_cleared_by_reset", 4'b0000, 64'd0, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd7, 5'd0); setMemwb(5'd7, 32'hA5A50007);
        applyStimulus("memwb_fwd", 4'b0010, 64'd0, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd7, 5'd0);
        applyStimulus("hist0_fwd", 4'b0011, {32'd0, 32'hA5A50007}, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd7, 5'd0);
        applyStimulus("hist1_fwd", 4'b0011, {32'd0, 32'hA5A50007}, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd7, 5'd0);
        applyStimulus("hist_expired", 4'b0000, 64'd0, 1'b0, 1'b0);

        nextCycle(); exmem_wb = 1'b1; exmem_waddr = 5'd5; setMemwb(5'd5, 32'h55); setSrc(5'd5, 5'd5);
        applyStimulus("exmem_priority", 4'b0101, 64'd0, 1'b0, 1'b0);
        nextCycle(); exmem_wb = 1'b1; exmem_waddr = 5'd6; setMemwb(5'd5, 32'h66); setSrc(5'd5, 5'd5);
        applyStimulus("memwb_over_hist", 4'b1010, 64'd0, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd5, 5'd5);
        applyStimulus("newest_hist_wins", 4'b1111, {32'h66, 32'h66}, 1'b0, 1'b0);
        nextCycle(); exmem_wb = 1'b1; exmem_waddr = 5'd0; setMemwb(5'd0, 32'h99); setSrc(5'd0, 5'd0);
        applyStimulus("r0_never_fwd", 4'b0000, 64'd0, 1'b0, 1'b0);
        nextCycle(); exmem_waddr = 5'd4; memwb_waddr = 5'd4; memwb_wdata = 32'h1; setSrc(5'd4, 5'd4);
        applyStimulus("wb_disabled", 4'b0000, 64'd0, 1'b0, 1'b0);

        nextCycle(); setLoad(5'd8, 5'd0, 5'd8, 2'b10);
        applyStimulus("lu_stall_c1", 4'b0000, 64'd0, 1'b1, 1'b1);
        nextCycle(); setMemwb(5'd8, 32'hDEADBEEF);
        applyStimulus("lu_stall_c2", 4'b0000, 64'd0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus("lu_stall_c3", 4'b0000, 64'd0, 1'b1, 1'b0);
        nextCycle(); setSrc(5'd8, 5'd0);
        applyStimulus("lu_release_hist", 4'b0011, {32'd0, 32'hDEADBEEF}, 1'b0, 1'b0);
        nextCycle(); setLoad(5'd8, 5'd0, 5'd8, 2'b01);
        applyStimulus("lu_operand_unused", 4'b0000, 64'd0, 1'b0, 1'b0);

        for (int c = 0; c < 3; c++) begin
            nextCycle(); setLoad(5'd8, 5'd8, 5'd0, 2'b01);
            applyStimulus("b2b_stall", 4'b0000, 64'd0, 1'b1, 1'b1);
        end
        nextCycle(); setLoad(5'd8, 5'd8, 5'd0, 2'b01); setMemwb(5'd9, 32'h99);
        applyStimulus("b2b_no_dead_cycle", 4'b0000, 64'd0, 1'b1, 1'b1);
        nextCycle(); reset = 1'b1; setSrc(5'd9, 5'd0); setLoad(5'd8, 5'd8, 5'd0, 2'b01);
        applyStimulus("reset_mid_stall", 4'b0011, {32'd0, 32'h99}, 1'b0, 1'b0);
        nextCycle(); setSrc(5'd9, 5'd0);
        applyStimulus("post_reset_idle", 4'b0000, 64'd0, 1'b0, 1'b0);

        nextCycle(); setLoad(5'd8, 5'd0, 5'd8, 2'b11);
        applyStimulus("relu_c1", 4'b0000, 64'd0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus("relu_c2", 4'b0000, 64'd0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus("relu_c3", 4'b0000, 64'd0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus("relu_done", 4'b0000, 64'd0, 1'b0, 1'b0);

        guard = 0;
        while ((exp_q.size() > 0) && (guard < 10)) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
